mips_cpu_pc_unit: RTL and testbench

- Parametrised program-counter unit for the MIPS-compatible core.
- Resolves branch/jump conditions from register operands, computes targets and sequences MIPS branch-delay-slot redirection. Also generates link addresses, halt detection and misalignment faults.
- Sits between decode/register-read and the instruction-fetch address port.

---
 rtl/mips_cpu_pkg.sv | 33 +++
 rtl/mips_cpu_pc_unit_if.sv | 32 +++
 rtl/mips_cpu_br_cond.sv | 34 +++
 rtl/mips_cpu_pc_unit.sv | 92 +++++++++
 tb/tb_mips_cpu_pc_unit.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_cpu_pkg.sv
// Shared types and constants for the MIPS-compatible core's PC unit.
//   br_op_t    : branch/jump operation selected by decode.
//   pc_state_t : PC sequencer states.
//   br_offset  : sign-extended word offset -> byte offset.
package mips_cpu_pkg;

    typedef enum logic [3:0] {
        BR_NONE = 4'd0,
        BR_EQ   = 4'd1,
        BR_NE   = 4'd2,
        BR_GEZ  = 4'd3,
        BR_GTZ  = 4'd4,
        BR_LEZ  = 4'd5,
        BR_LTZ  = 4'd6,
        BR_J    = 4'd7,
        BR_JR   = 4'd8
    } br_op_t;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_SLOT   = 2'd1,
        ST_HALTED = 2'd2,
        ST_FAULT  = 2'd3
    } pc_state_t;

    localparam logic [31:0] RESET_VECTOR_DEF = 32'hBFC0_0000;
    localparam logic [31:0] HALT_ADDR_DEF    = 32'h0000_0000;

    function automatic logic [31:0] br_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/mips_cpu_pc_unit_if.sv
// Decode-side bus of the PC unit.
//   master : decode/register-read stage (drives operands, sees pc/link).
//   slave  : mips_cpu_pc_unit.
// Signals: pc_en, br_op, link_req, rs_val, rt_val, imm16, instr_index (to
// the unit); pc, link_addr, link_we, active, fault (from the unit).
interface mips_cpu_pc_unit_if;
    import mips_cpu_pkg::*;

    logic        pc_en;
    br_op_t      br_op;
    logic        link_req;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [15:0] imm16;
    logic [25:0] instr_index;
    logic [31:0] pc;
    logic [31:0] link_addr;
    logic        link_we;
    logic        active;
    logic        fault;

    modport master (
        output pc_en, br_op, link_req, rs_val, rt_val, imm16, instr_index,
        input  pc, link_addr, link_we, active, fault
    );

    modport slave (
        input  pc_en, br_op, link_req, rs_val, rt_val, imm16, instr_index,
        output pc, link_addr, link_we, active, fault
    );

endinterface

// File: rtl/mips_cpu_br_cond.sv
// Branch condition resolver: br_op + register operands -> taken.
//   br_op_i : operation, rs_i/rt_i : operands, taken_o : condition holds.
// Zero-compares are signed; J/JR are unconditional.
module mips_cpu_br_cond
    import mips_cpu_pkg::*;
(
    input  br_op_t      br_op_i,
    input  logic [31:0] rs_i,
    input  logic [31:0] rt_i,
    output logic        taken_o
);

    logic rs_neg;
    logic rs_zero;

    assign rs_neg  = rs_i[31];
    assign rs_zero = (rs_i == 32'd0);

    always_comb begin
        taken_o = 1'b0;
        case (br_op_i)
            BR_EQ:   taken_o = (rs_i == rt_i);
            BR_NE:   taken_o = (rs_i != rt_i);
            BR_GEZ:  taken_o = !rs_neg;
            BR_GTZ:  taken_o = !rs_neg && !rs_zero;
            BR_LEZ:  taken_o = rs_neg || rs_zero;
            BR_LTZ:  taken_o = rs_neg;
            BR_J,
            BR_JR:   taken_o = 1'b1;
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_cpu_pc_unit.sv
// Program-counter unit: resolves branches, computes targets, sequences the
// branch delay slot, produces link address/enable, halt and fault status.
//   clk, reset_n : clock and asynchronous active-low reset.
//   bus (slave)  : decode-side operands in; pc, link_addr, link_we,
//                  active and fault out.
module mips_cpu_pc_unit
    import mips_cpu_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR  = RESET_VECTOR_DEF,
    parameter logic [31:0] HALT_ADDR     = HALT_ADDR_DEF,
    parameter bit          DELAY_SLOT_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    mips_cpu_pc_unit_if.slave    bus
);

    pc_state_t   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_q, pend_d;
    logic [31:0] p4;
    logic [31:0] target;
    logic        taken;

    mips_cpu_br_cond u_br_cond (
        .br_op_i (bus.br_op),
        .rs_i    (bus.rs_val),
        .rt_i    (bus.rt_val),
        .taken_o (taken)
    );

    assign p4 = pc_q + 32'd4;

    always_comb begin
        target = p4 + br_offset(bus.imm16);
        case (bus.br_op)
            BR_J:    target = {p4[31:28], bus.instr_index, 2'b00};
            BR_JR:   target = bus.rs_val;
            default: target = p4 + br_offset(bus.imm16);
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        if (bus.pc_en) begin
            case (state_q)
                ST_RUN: begin
                    if (!taken) begin
                        pc_d = p4;
                    end else if (target[1:0] != 2'b00) begin
                        // pc stays on the offending branch for debug
                        state_d = ST_FAULT;
                    end else if (DELAY_SLOT_EN) begin
                        pc_d    = p4;
                        pend_d  = target;
                        state_d = ST_SLOT;
                    end else begin
                        pc_d = target;
                        if (target == HALT_ADDR) state_d = ST_HALTED;
                    end
                end
                ST_SLOT: begin
                    // whatever decode presents in the slot is ignored
                    pc_d    = pend_q;
                    state_d = (pend_q == HALT_ADDR) ? ST_HALTED : ST_RUN;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_VECTOR;
            pend_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
        end
    end

    assign bus.pc        = pc_q;
    assign bus.link_addr = pc_q + 32'd8;
    assign bus.link_we   = bus.link_req && bus.pc_en && (state_q == ST_RUN);
    assign bus.active    = (state_q == ST_RUN) || (state_q == ST_SLOT);
    assign bus.fault     = (state_q == ST_FAULT);

endmodule

// File: tb/tb_mips_cpu_pc_unit.sv
module tb_mips_cpu_pc_unit;
    import mips_cpu_pkg::*;

    localparam logic [31:0] RV = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        pc_en = 1'b1;
    br_op_t      br_op = BR_NONE;
    logic        link_req = 1'b0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic [15:0] imm16 = '0;
    logic [25:0] instr_index = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mips_cpu_pc_unit_if if_ds ();
    mips_cpu_pc_unit_if if_nd ();

    assign if_ds.pc_en = pc_en;        assign if_nd.pc_en = pc_en;
    assign if_ds.br_op = br_op;        assign if_nd.br_op = br_op;
    assign if_ds.link_req = link_req;  assign if_nd.link_req = link_req;
    assign if_ds.rs_val = rs_val;      assign if_nd.rs_val = rs_val;
    assign if_ds.rt_val = rt_val;      assign if_nd.rt_val = rt_val;
    assign if_ds.imm16 = imm16;        assign if_nd.imm16 = imm16;
    assign if_ds.instr_index = instr_index;
    assign if_nd.instr_index = instr_index;

    mips_cpu_pc_unit #(.DELAY_SLOT_EN(1'b1)) u_ds (
        .clk(clk), .reset_n(reset_n), .bus(if_ds.slave)
    );
    mips_cpu_pc_unit #(.DELAY_SLOT_EN(1'b0)) u_nd (
        .clk(clk), .reset_n(reset_n), .bus(if_nd.slave)
    );

    // ---------------- behavioural model (index 0: slot build, 1: no-slot)
    // mode: 0 running, 1 waiting in delay slot, 2 halted, 3 faulted
    logic [31:0] m_pc [2];
    logic [31:0] m_pend [2];
    int          m_mode [2];

    function automatic bit m_taken();
        case (br_op)
            BR_EQ:  return rs_val == rt_val;
            BR_NE:  return rs_val != rt_val;
            BR_GEZ: return $signed(rs_val) >= 0;
            BR_GTZ: return $signed(rs_val) > 0;
            BR_LEZ: return $signed(rs_val) <= 0;
            BR_LTZ: return $signed(rs_val) < 0;
            BR_J, BR_JR: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] m_target(input logic [31:0] pc);
        logic [31:0] p4;
        logic [31:0] off;
        p4 = pc + 32'd4;
        off = 32'($signed(imm16)) * 32'd4;
        if (br_op == BR_J) return {p4[31:28], instr_index, 2'b00};
        if (br_op == BR_JR) return rs_val;
        return p4 + off;
    endfunction

    function automatic logic [31:0] f_pc(input bit ds, input int mode,
                                         input logic [31:0] pc, input logic [31:0] pend);
        logic [31:0] tg;
        if (mode == 1) return pend;
        if (mode != 0) return pc;
        if (!m_taken()) return pc + 32'd4;
        tg = m_target(pc);
        if (tg % 4 != 0) return pc;
        return ds ? pc + 32'd4 : tg;
    endfunction

    function automatic int f_mode(input bit ds, input int mode,
                                  input logic [31:0] pc, input logic [31:0] pend);
        logic [31:0] tg;
        if (mode == 1) return (pend == 32'd0) ? 2 : 0;
        if (mode != 0) return mode;
        if (!m_taken()) return 0;
        tg = m_target(pc);
        if (tg % 4 != 0) return 3;
        if (ds) return 1;
        return (tg == 32'd0) ? 2 : 0;
    endfunction

    function automatic logic [31:0] f_pend(input bit ds, input int mode,
                                           input logic [31:0] pc, input logic [31:0] pend);
        logic [31:0] tg;
        tg = m_target(pc);
        if (ds && mode == 0 && m_taken() && tg % 4 == 0) return tg;
        return pend;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                m_pc[i] <= RV;
                m_pend[i] <= '0;
                m_mode[i] <= 0;
            end
        end else if (pc_en) begin
            for (int i = 0; i < 2; i++) begin
                m_pc[i]   <= f_pc(i == 0, m_mode[i], m_pc[i], m_pend[i]);
                m_mode[i] <= f_mode(i == 0, m_mode[i], m_pc[i], m_pend[i]);
                m_pend[i] <= f_pend(i == 0, m_mode[i], m_pc[i], m_pend[i]);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("ds_pc", if_ds.pc, m_pc[0]);
        chk("ds_link_addr", if_ds.link_addr, m_pc[0] + 32'd8);
        chk("ds_link_we", 32'(if_ds.link_we), 32'(link_req && pc_en && m_mode[0] == 0));
        chk("ds_active", 32'(if_ds.active), 32'(m_mode[0] < 2));
        chk("ds_fault", 32'(if_ds.fault), 32'(m_mode[0] == 3));
        chk("nd_pc", if_nd.pc, m_pc[1]);
        chk("nd_link_we", 32'(if_nd.link_we), 32'(link_req && pc_en && m_mode[1] == 0));
        chk("nd_active", 32'(if_nd.active), 32'(m_mode[1] < 2));
        chk("nd_fault", 32'(if_nd.fault), 32'(m_mode[1] == 3));
    end

    // ---------------- directed stimulus with literal expectations
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drv(input br_op_t op, input logic lr, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [15:0] imm, input logic [25:0] idx);
        br_op = op; link_req = lr; rs_val = rs; rt_val = rt; imm16 = imm; instr_index = idx;
    endtask

    br_op_t      ops [8] = '{BR_NE, BR_GEZ, BR_GTZ, BR_LEZ, BR_LTZ, BR_GEZ, BR_LEZ, BR_NE};
    logic [31:0] rsv [8] = '{32'd5, 32'd0, 32'd0, 32'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd1, 32'd7};
    logic [31:0] rtv [8] = '{32'd5, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd9};

    initial begin
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        #1;
        chk("rst_pc", if_ds.pc, RV);
        chk("rst_active", 32'(if_ds.active), 32'd1);
        chk("rst_fault", 32'(if_ds.fault), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("seq_pc", if_ds.pc, RV + 32'(4 * k));
        end
        tick();
        // taken EQ backwards
        drv(BR_EQ, 0, 32'd5, 32'd5, 16'hFFFC, '0);
        tick();
        chk("eq_slot_pc", if_ds.pc, 32'hBFC0_0014);
        chk("eq_noslot_pc", if_nd.pc, 32'hBFC0_0004);
        drv(BR_NONE, 0, 0, 0, 0, 0);
        tick();
        chk("eq_target_pc", if_ds.pc, 32'hBFC0_0004);
        repeat (3) tick();
        // not-taken EQ
        drv(BR_EQ, 0, 32'd5, 32'd6, 16'hFFFC, '0);
        tick();
        chk("eqnt_pc1", if_ds.pc, 32'hBFC0_0014);
        drv(BR_NONE, 0, 0, 0, 0, 0);
        tick();
        chk("eqnt_pc2", if_ds.pc, 32'hBFC0_0018);
        // stall in the slot
        drv(BR_EQ, 0, 32'd1, 32'd1, 16'h0010, '0);
        tick();
        chk("stall_slot_pc", if_ds.pc, 32'hBFC0_001C);
        pc_en = 1'b0;
        drv(BR_NONE, 0, 0, 0, 0, 0);
        repeat (4) begin
            tick();
            chk("stall_hold_pc", if_ds.pc, 32'hBFC0_001C);
        end
        pc_en = 1'b1;
        tick();
        chk("stall_release_pc", if_ds.pc, 32'hBFC0_005C);
        // reset while in the slot drops the pending redirect
        drv(BR_EQ, 0, 32'd1, 32'd1, 16'h0004, '0);
        tick();
        chk("rslot_pc", if_ds.pc, 32'hBFC0_0060);
        drv(BR_NONE, 0, 0, 0, 0, 0);
        reset_n = 1'b0;
        #1;
        chk("rslot_async_pc", if_ds.pc, RV);
        tick();
        reset_n = 1'b1;
        tick();
        chk("rslot_after_pc", if_ds.pc, 32'hBFC0_0004);
        repeat (7) tick();
        // BLTZAL not taken still links
        drv(BR_LTZ, 1, 32'd1, 0, 16'h0040, '0);
        #1;
        chk("bltzal_we", 32'(if_ds.link_we), 32'd1);
        chk("bltzal_addr", if_ds.link_addr, 32'hBFC0_0028);
        tick();
        chk("bltzal_pc", if_ds.pc, 32'hBFC0_0024);
        // JAL
        drv(BR_J, 1, 0, 0, 0, 26'h000_0100);
        #1;
        chk("jal_we", 32'(if_ds.link_we), 32'd1);
        chk("jal_addr", if_ds.link_addr, 32'hBFC0_002C);
        tick();
        chk("jal_slot_pc", if_ds.pc, 32'hBFC0_0028);
        // branch in the delay slot: no effect, no link
        drv(BR_JR, 1, 32'h0000_1000, 0, 0, 0);
        #1;
        chk("slot_link_we", 32'(if_ds.link_we), 32'd0);
        tick();
        chk("jal_target_pc", if_ds.pc, 32'hB000_0400);
        // JR to halt address
        drv(BR_JR, 0, 32'd0, 0, 0, 0);
        tick();
        chk("halt_slot_pc", if_ds.pc, 32'hB000_0404);
        drv(BR_NONE, 0, 0, 0, 0, 0);
        tick();
        chk("halt_pc", if_ds.pc, 32'd0);
        chk("halt_active", 32'(if_ds.active), 32'd0);
        drv(BR_NONE, 1, 0, 0, 0, 0);
        #1;
        chk("halt_link_we", 32'(if_ds.link_we), 32'd0);
        repeat (2) tick();
        chk("halt_hold_pc", if_ds.pc, 32'd0);
        // misaligned JR target
        drv(BR_NONE, 0, 0, 0, 0, 0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        #1;
        chk("rst2_pc", if_ds.pc, RV);
        chk("rst2_active", 32'(if_ds.active), 32'd1);
        drv(BR_JR, 0, 32'hBFC0_0102, 0, 0, 0);
        tick();
        chk("fault_flag", 32'(if_ds.fault), 32'd1);
        chk("fault_pc", if_ds.pc, RV);
        chk("fault_active", 32'(if_ds.active), 32'd0);
        drv(BR_NONE, 0, 0, 0, 0, 0);
        repeat (2) tick();
        chk("fault_sticky", 32'(if_ds.fault), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("fault_cleared", 32'(if_ds.fault), 32'd0);
        tick();
        reset_n = 1'b1;
        // remaining conditions, including signed boundaries
        for (int i = 0; i < 8; i++) begin
            drv(ops[i], 0, rsv[i], rtv[i], 16'h0002, '0);
            tick();
            drv(BR_NONE, 0, 0, 0, 0, 0);
            tick();
        end
        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
